// File: rtl/mod_n_ctr.sv
// mod_n_ctr: free-running modulo-N up-counter.
// Counts 0..N-1 and wraps to 0, one step per rising clk edge. tc flags the
// terminal value, and wrap_cnt counts completed wraps modulo 2^WRAP_W.
// rstn is an asynchronous, active-HIGH reset despite its name.

module mod_n_ctr #(
    parameter int N      = 10,
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt
);

    // Terminal value. It is held at WIDTH bits, so the unsigned compare is
    // done at the width of the count itself.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    // Elaboration-time parameter legality checks.
    if (N < 32'sd2) begin : g_chk_n_min
        $fatal(1, "mod_n_ctr: N must be at least 2");
    end
    if ((WIDTH < 32'sd31) && (N > (32'sd1 <<< WIDTH))) begin : g_chk_n_max
        $fatal(1, "mod_n_ctr: N must not exceed 2^WIDTH");
    end
    if (WRAP_W < 32'sd1) begin : g_chk_wrap_w
        $fatal(1, "mod_n_ctr: WRAP_W must be at least 1");
    end

    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  out_d;
    logic [WRAP_W-1:0] wrap_q;
    logic [WRAP_W-1:0] wrap_d;

    // Next-state logic: wrap at the terminal value and bump the wrap counter,
    // otherwise increment. An out-of-range count (upset) reloads 0 without
    // counting as a wrap.
    always_comb begin
        out_d  = out_q;
        wrap_d = wrap_q;
        if (out_q == LAST) begin
            // The wrap comes from this compare, so N == 2^WIDTH behaves the
            // same as any other modulus and never relies on overflow.
            out_d  = {WIDTH{1'b0}};
            wrap_d = wrap_q + WRAP_W'(1);
        end else if (out_q < LAST) begin
            out_d  = out_q + WIDTH'(1);
        end else begin
            out_d  = {WIDTH{1'b0}};
        end
    end

    // State registers. The asynchronous reset clears both counters at once
    // and takes priority over a coincident clock edge.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_q  <= {WIDTH{1'b0}};
            wrap_q <= {WRAP_W{1'b0}};
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out      = out_q;
    assign wrap_cnt = wrap_q;
    // tc is decoded combinationally from the count, so it is high for
    // exactly one cycle in every N.
    assign tc       = (out_q == LAST);

endmodule

// File: tb/tb_mod_n_ctr.sv
// Testbench for mod_n_ctr: three instances (N=10; N=16 full range; N=2 with a
// 2-bit wrap counter) share one clock and one reset. The stimulus process
// tracks the number of counting edges since the last reset and pushes the
// expected outputs of all three instances into a scoreboard queue. A separate
// monitor pops one entry on every falling edge and compares it with the DUTs.

module tb_mod_n_ctr;

    logic       clk = 1'b0;
    logic       rstn;

    logic [3:0] a_out;
    logic       a_tc;
    logic [7:0] a_wrap;
    logic [3:0] b_out;
    logic       b_tc;
    logic [7:0] b_wrap;
    logic [0:0] c_out;
    logic       c_tc;
    logic [1:0] c_wrap;

    mod_n_ctr #(.N(10), .WIDTH(4), .WRAP_W(8)) u_a (
        .clk(clk), .rstn(rstn), .out(a_out), .tc(a_tc), .wrap_cnt(a_wrap)
    );
    mod_n_ctr #(.N(16), .WIDTH(4), .WRAP_W(8)) u_b (
        .clk(clk), .rstn(rstn), .out(b_out), .tc(b_tc), .wrap_cnt(b_wrap)
    );
    mod_n_ctr #(.N(2), .WIDTH(1), .WRAP_W(2)) u_c (
        .clk(clk), .rstn(rstn), .out(c_out), .tc(c_tc), .wrap_cnt(c_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a_out, a_tc, a_wrap;
        int unsigned b_out, b_tc, b_wrap;
        int unsigned c_out, c_tc, c_wrap;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned edges;   // counting edges seen since reset was last released
    int          checks = 0;
    int          passed = 0;

    // Reference model: after k counting edges, the count is k mod N, the wrap
    // counter is floor(k / N) mod 2^WRAP_W, and tc marks the value N-1.
    function automatic exp_t model(input int unsigned k);
        exp_t e;
        e.a_out  = k % 10;
        e.a_tc   = (e.a_out == 9) ? 1 : 0;
        e.a_wrap = (k / 10) % 256;
        e.b_out  = k % 16;
        e.b_tc   = (e.b_out == 15) ? 1 : 0;
        e.b_wrap = (k / 16) % 256;
        e.c_out  = k % 2;
        e.c_tc   = (e.c_out == 1) ? 1 : 0;
        e.c_wrap = (k / 2) % 4;
        return e;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t, edges=%0d)", name, act, exp, $time, edges);
        end
    endtask

    // One clock cycle of stimulus: account for the edge just taken, then
    // (2 time units later, well between edges) drive the reset level for the
    // rest of the cycle and push what the DUTs should show at the next
    // falling edge. Asserting reset here is checked before any further edge.
    task automatic cycle(input logic rst_val);
        @(posedge clk);
        if (rstn == 1'b0) edges = edges + 1;
        else              edges = 0;
        #2;
        rstn = rst_val;
        if (rst_val) edges = 0;
        sb_q.push_back(model(edges));
    endtask

    // Monitor: one scoreboard entry is consumed on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check("scoreboard_entry_present", 0, 1);
            end else begin
                e = sb_q.pop_front();
                check("no_x", $isunknown({a_out, a_tc, a_wrap, b_out, b_tc, b_wrap, c_out, c_tc, c_wrap}) ? 1 : 0, 0);
                check("n10_out",  a_out,  e.a_out);
                check("n10_tc",   a_tc,   e.a_tc);
                check("n10_wrap", a_wrap, e.a_wrap);
                check("n16_out",  b_out,  e.b_out);
                check("n16_tc",   b_tc,   e.b_tc);
                check("n16_wrap", b_wrap, e.b_wrap);
                check("n2_out",   c_out,  e.c_out);
                check("n2_tc",    c_tc,   e.c_tc);
                check("n2_wrap",  c_wrap, e.c_wrap);
            end
        end
    end

    initial begin
        rstn  = 1'b1;
        edges = 0;

        // Reset held across several edges: everything stays at 0.
        repeat (3) cycle(1'b1);

        // Release, then 20 counting edges (two full N=10 periods).
        cycle(1'b0);
        repeat (20) cycle(1'b0);

        // Advance to count 6 on the N=10 instance, then reset between edges.
        while ((edges % 10) != 6) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        repeat (40) cycle(1'b0);

        // Long run so the 8-bit wrap counter of the N=10 instance rolls over.
        repeat (2600) cycle(1'b0);

        // Randomized reset activity: short random reset pulses between runs.
        repeat (600) begin
            if (rstn) cycle(($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);
            else      cycle(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
        end
        cycle(1'b0);
        repeat (30) cycle(1'b0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mod_n_ctr.md
Name: mod_n_ctr

Overview:
- Free-running modulo-N up-counter: counts 0, 1, …, N-1, then wraps to 0, one step per rising clock edge.
- Used as a general-purpose cycle divider/sequencer and as the reference DUT for the counter test bench.
- Also provides a terminal-count flag and a wrap counter for downstream dividers.

Parameters:
- N, 10, modulus; legal range 2..2^WIDTH.
- WIDTH, 4, width of the count output in bits.
- WRAP_W, 8, width of the wrap counter output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rstn  input  1  asynchronous reset, active-high: 1 = reset asserted, 0 = run.
- out  output  WIDTH  current count value, 0..N-1.
- tc  output  1  terminal count; high while out == N-1.
- wrap_cnt  output  WRAP_W  number of completed wraps, modulo 2^WRAP_W.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on port rstn.
- Reset:
  - rstn = 1 forces out = 0 and wrap_cnt = 0 immediately, without waiting for a clock edge.
  - While reset is held, tc = 0 (because out = 0 and N ≥ 2).
  - Reset asserted mid-count clears the outputs at once. The next count starts from 0.
- Counting (rstn = 0), on each rising clk edge:
  - if out == N-1: out <= 0 and wrap_cnt <= wrap_cnt + 1 (wraps naturally at 2^WRAP_W);
  - else: out <= out + 1.
- Latency after reset release:
  - the first rising edge with rstn = 0 moves out from 0 to 1;
  - no synchronizer stage, no dead cycle.
- tc is combinational from out: tc = (out == N-1). It is high for exactly 1 cycle in every N.
- Arithmetic:
  - the unsigned compare against N-1 is done at WIDTH bits;
  - out never takes a value ≥ N;
  - when N == 2^WIDTH, the wrap from N-1 to 0 happens through the compare, not through overflow; behaviour is identical either way.
- Illegal values:
  - out can never reach a value ≥ N;
  - if it does so through an X/upset, the next edge loads 0 without incrementing wrap_cnt.
- Parameter checks at elaboration:
  - N < 2 is a fatal error;
  - N > 2^WIDTH is a fatal error;
  - WRAP_W < 1 is a fatal error.
- Reset-vs-clock collision: if rstn rises on the same edge as clk, reset wins and out = 0.
- No enable or load input. The counter always runs when out of reset.

Test Plan:
- Reset hold: N=10, WIDTH=4; rstn=1 for 2 clk edges -> out=0x0, tc=0, wrap_cnt=0 throughout; no change on clk edges.
- Full sequence: release rstn (0) and run 20 edges -> out = 1,2,…,9,0,1,…,9,0.
  - tc=1 exactly while out=9;
  - wrap_cnt=1 after the 10th edge and 2 after the 20th.
- Async reset mid-count: rstn=1 asserted between edges while out=6 -> out=0 immediately, before the next edge; wrap_cnt=0.
  - Then release -> the next edge gives out=1.
- Full-range modulus: N=16, WIDTH=4 -> out runs 0..15, wraps to 0 on the 16th edge; tc high at 15; no X.
- Minimum modulus: N=2 -> out toggles 0,1,0,1; tc mirrors out; wrap_cnt increments every 2 edges.
- Wrap counter rollover: N=2, WRAP_W=2, run 8 edges -> wrap_cnt goes 1,2,3,0.
